// File: rtl/input_arbiter.sv
// Round-robin arbiter that shares one CPU input port among NUM_SRC byte producers.
// Each accepted byte is held with ready_in high for HOLD_CYCLES, then low for GAP_CYCLES.
module input_arbiter #(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  localparam int unsigned GidW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*BUS_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic [BUS_WIDTH-1:0]         in_port,
  output logic                         ready_in,
  output logic [GidW-1:0]              grant_id,
  output logic                         busy
);

  localparam int unsigned MaxCnt = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [1:0] {StIdle, StPresent, StRelease} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [GidW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GidW-1:0]      grant_id_q, grant_id_d;
  logic [BUS_WIDTH-1:0] in_port_q, in_port_d;
  logic                 ready_in_q, ready_in_d;

  logic [BUS_WIDTH-1:0] src_byte [NUM_SRC];
  logic                 gnt_found;
  logic [GidW-1:0]      gnt_idx;
  logic [GidW:0]        idx;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_byte[i] = src_data[i*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  // First valid source at or after rr_ptr, wrapping; the extra idx bit holds the unwrapped sum.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = {1'b0, rr_ptr_q} + (GidW+1)'(k);
      if (idx >= (GidW+1)'(NUM_SRC)) begin
        idx = idx - (GidW+1)'(NUM_SRC);
      end
      if (!gnt_found && src_valid[idx[GidW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[GidW-1:0];
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (state_q == StIdle && gnt_found && !reset) begin
      src_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    in_port_d  = in_port_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          in_port_d  = src_byte[gnt_idx];
          grant_id_d = gnt_idx;
          rr_ptr_d   = (gnt_idx == GidW'(NUM_SRC - 1)) ? '0 : gnt_idx + GidW'(1);
          cnt_d      = CntW'(HOLD_CYCLES - 1);
          state_d    = StPresent;
        end
      end
      StPresent: begin
        if (cnt_q == '0) begin
          state_d = StRelease;
          cnt_d   = CntW'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRelease: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    ready_in_d = (state_d == StPresent);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      in_port_q  <= '0;
      ready_in_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      in_port_q  <= in_port_d;
      ready_in_q <= ready_in_d;
    end
  end

  assign in_port  = in_port_q;
  assign ready_in = ready_in_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != StIdle);

  a_src_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(src_ready));
  a_ready_busy:       assert property (@(posedge clk) disable iff (reset) ready_in |-> busy);
  a_in_port_stable:   assert property (@(posedge clk) disable iff (reset)
                                       (busy && $past(busy)) |-> $stable(in_port));

endmodule
